sequential_multiplier: RTL and testbench
========================================

Name: sequential_multiplier

Overview:
Multi-cycle unsigned shift-and-add multiplier. It is the multiplication counterpart of the combinational restoring divider in the ALU. Operands arrive on a valid/ready input handshake and are processed at one multiplier bit per clock. The double-width product leaves on a valid/ready output handshake. The ALU uses ProductLow for MUL and ProductHigh for MULHU; signed variants are built in the ALU by operand/result sign correction.

Parameters:
l, 16, operand width in bits (l >= 2); product is 2l bits
cw, $clog2(l+1), iteration counter width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
A  input  l  multiplicand, unsigned
B  input  l  multiplier, unsigned
InValid  input  1  A/B valid this cycle
InReady  output  1  block can accept operands (high only in IDLE)
ProductLow  output  l  product bits [l-1:0]
ProductHigh  output  l  product bits [2l-1:l]
Overflow  output  1  ProductHigh != 0 (product does not fit in l bits)
OutValid  output  1  product/Overflow valid
OutReady  input  1  consumer accepts result

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, accumulator=0, ProductLow=0, ProductHigh=0, Overflow=0, OutValid=0. InReady=1 as soon as reset asserts.
- States: IDLE, RUN, DONE. InReady = (state==IDLE). OutValid = (state==DONE). Both are decoded from registered state only.
- Datapath: mcand reg [l-1:0]; acc reg [2l:0] (one guard bit). acc[l-1:0] holds the shifting multiplier; acc[2l:l] holds the partial sum.
- IDLE: accept on an edge with InValid & InReady. Then mcand<=A, acc<={(l+1)'b0, B}, counter<=0, state<=RUN. Without InValid, registers hold.
- RUN, one iteration per edge:
  - sum[l:0] = acc[2l-1:l] + (acc[0] ? mcand : 0).
  - acc <= {1'b0, sum, acc[l-1:1]} (add, then logical right shift by 1).
  - counter <= counter+1.
  - On the edge where counter==l-1: state<=DONE, and the final acc[2l-1:0] is written to ProductHigh/ProductLow.
  - Overflow <= (final high half != 0), registered on the same edge.
- Latency: accept edge E0, iterations on E1..El. OutValid is high in the cycle after El, i.e. exactly l+1 clocks after the accept edge. Fixed latency, no early termination for zero operands.
- DONE: outputs held stable while OutValid=1 and OutReady=0 (no change, no glitch). On an edge with OutReady=1: state<=IDLE, OutValid drops, InReady rises the next cycle. Product registers keep their last value in IDLE.
- No operand/result overlap: a new accept is only possible one cycle after the result handshake. Minimum issue interval is l+2 cycles.
- InValid while in RUN or DONE is ignored. Operands are not captured and are not queued.
- A and B may change freely after the accept edge; results depend only on captured values.
- OutReady while not in DONE is ignored.
- Width rule: the unsigned product is < 2^(2l), so the guard bit acc[2l] is always 0 after each shift. The sum carry lands in acc[2l-1].
- Reset mid-RUN or mid-DONE: returns to IDLE immediately, the in-flight result is discarded, and OutValid never asserts for it.
- Boundaries:
  - A=0 or B=0: product 0, Overflow 0, same latency.
  - A=B=2^l-1: maximal product, no lost carry.

Test Plan:
- l=16, A=3, B=5, OutReady=1 -> OutValid exactly 17 cycles after accept; ProductLow=0x000F, ProductHigh=0x0000, Overflow=0; InReady high the next cycle.
- A=0xFFFF, B=0xFFFF -> ProductHigh=0xFFFE, ProductLow=0x0001, Overflow=1.
- A=0x1234, B=0 and A=0, B=0xFFFF -> product 0, Overflow=0, latency still 17.
- A=0x0100, B=0x0100 with OutReady held 0 for 5 cycles after OutValid -> ProductHigh=0x0001, ProductLow=0x0000 stable all 5 cycles; InValid pulses with A=7, B=7 during RUN/DONE are ignored. After handshake, accept A=7, B=7 -> 0x0031.
- Assert rst_n=0 at iteration 8 of A=0xABCD, B=0x1234 -> outputs zero immediately, InReady=1, no OutValid. Next op A=2, B=0x8000 -> ProductHigh=0x0001, ProductLow=0x0000, Overflow=1.
- 500 random A/B pairs with random InValid/OutReady gaps -> each result equals A*B (32-bit reference model), Overflow==(A*B>=2^16), one result per accept, in order.

Source files
------------

// File: rtl/sequential_multiplier.sv
// sequential_multiplier
//
// Multi-cycle unsigned shift-and-add multiplier, one multiplier bit per clock.
// This is the multiplication counterpart of the ALU's restoring divider. The
// ALU takes ProductLow for MUL and ProductHigh for MULHU. Signed forms are
// produced outside this block by sign correction.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   A, B        multiplicand / multiplier (l bits, unsigned)
//   InValid     operands valid this cycle
//   InReady     block can accept operands (IDLE only)
//   ProductLow  product bits [l-1:0]
//   ProductHigh product bits [2l-1:l]
//   Overflow    high half of the product is non-zero
//   OutValid    product and Overflow valid (DONE only)
//   OutReady    consumer accepts the result
//
// Timing: operands are accepted on edge E0. Iterations run on edges E1..El.
// The result is presented from El onward and is held until OutReady is seen.
module sequential_multiplier #(
  parameter int l = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [l-1:0]   A,
  input  logic [l-1:0]   B,
  input  logic           InValid,
  output logic           InReady,
  output logic [l-1:0]   ProductLow,
  output logic [l-1:0]   ProductHigh,
  output logic           Overflow,
  output logic           OutValid,
  input  logic           OutReady
);

  localparam int cw = $clog2(l + 1);
  localparam logic [cw-1:0] LAST_ITER = cw'(l - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [cw-1:0] cnt_q,     cnt_d;
  logic [l-1:0]  mcand_q,   mcand_d;
  // acc[l-1:0] holds the multiplier as it shifts out.
  // acc[2l:l] holds the partial sum. The top bit is a guard bit.
  logic [2*l:0]  acc_q,     acc_d;
  logic [l-1:0]  prod_lo_q, prod_lo_d;
  logic [l-1:0]  prod_hi_q, prod_hi_d;
  logic          ovf_q,     ovf_d;

  logic [l:0]    sum;
  logic [2*l:0]  acc_shift;

  // One shift-and-add step.
  // The guard bit is always zero after a shift, so including it in the add
  // is equivalent to adding only acc[2l-1:l]. Any carry out of the add ends
  // up in sum[l], which lands in acc[2l-1] after the shift.
  always_comb begin
    sum       = acc_q[2*l:l] + {1'b0, (acc_q[0] ? mcand_q : {l{1'b0}})};
    acc_shift = {1'b0, sum, acc_q[l-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          mcand_d = A;
          acc_d   = {{(l+1){1'b0}}, B};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + cw'(1);
        // The last iteration publishes its own result directly, so the
        // product registers are valid in the same cycle that DONE appears.
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          prod_hi_d = acc_shift[2*l-1:l];
          prod_lo_d = acc_shift[l-1:0];
          ovf_d     = |acc_shift[2*l-1:l];
        end
      end
      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      ovf_q     <= ovf_d;
    end
  end

  // Handshake flags are decoded from the state register alone.
  assign InReady     = (state_q == IDLE);
  assign OutValid    = (state_q == DONE);
  assign ProductLow  = prod_lo_q;
  assign ProductHigh = prod_hi_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb_sequential_multiplier
//
// Self-checking bench for sequential_multiplier with l=16.
// The expected results come from plain 32-bit multiplication of the operands
// the bench drives. A queue holds one expected product per accepted operand
// pair.
module tb_sequential_multiplier;

  localparam int L       = 16;
  localparam int TIMEOUT = 200;

  logic          clk;
  logic          rst_n;
  logic [L-1:0]  A;
  logic [L-1:0]  B;
  logic          InValid;
  logic          InReady;
  logic [L-1:0]  ProductLow;
  logic [L-1:0]  ProductHigh;
  logic          Overflow;
  logic          OutValid;
  logic          OutReady;

  int n_checks;
  int n_fails;
  logic [31:0] exp_q[$];

  sequential_multiplier #(.l(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .InValid    (InValid),
    .InReady    (InReady),
    .ProductLow (ProductLow),
    .ProductHigh(ProductHigh),
    .Overflow   (Overflow),
    .OutValid   (OutValid),
    .OutReady   (OutReady)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison.
  // Every check counts toward the summary. A mismatch is reported with the
  // observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Moves to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands while the block is ready. They are captured on the
  // following edge, and the expected product is queued.
  task automatic applyStimulus(input logic [L-1:0] a, input logic [L-1:0] b);
    int waited;
    waited = 0;
    while (InReady !== 1'b1 && waited < TIMEOUT) begin
      step();
      waited++;
    end
    if (InReady !== 1'b1) checkOutput("inready_timeout", 32'(InReady), 32'd1);
    A       = a;
    B       = b;
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    exp_q.push_back(32'(a) * 32'(b));
  endtask

  // Counts edges until OutValid appears.
  // Optionally it throws ignored InValid traffic at the block while waiting.
  task automatic waitResult(input bit junk, output int edges);
    edges = 0;
    while (OutValid !== 1'b1 && edges < TIMEOUT) begin
      if (junk) begin
        InValid = 1'($urandom);
        A       = 16'($urandom);
        B       = 16'($urandom);
      end
      step();
      edges++;
    end
    InValid = 1'b0;
    if (OutValid !== 1'b1) checkOutput("outvalid_timeout", 32'(OutValid), 32'd1);
  endtask

  // Compares the presented result with the oldest queued product.
  task automatic checkResult(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      checkOutput({tag, "_lo"},  32'(ProductLow),  {16'd0, exp[15:0]});
      checkOutput({tag, "_hi"},  32'(ProductHigh), {16'd0, exp[31:16]});
      checkOutput({tag, "_ovf"}, 32'(Overflow),    32'(exp >= 32'h0001_0000));
    end
  endtask

  // Takes the result and confirms the block is back in IDLE.
  task automatic handshake(input string tag);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    checkOutput({tag, "_outvalid_drop"}, 32'(OutValid), 32'd0);
    checkOutput({tag, "_inready_rise"},  32'(InReady),  32'd1);
  endtask

  // Returns 0 or all-ones now and then, otherwise a random value.
  function automatic logic [L-1:0] pickOperand();
    logic [L-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      default: v = L'($urandom);
    endcase
    return v;
  endfunction

  // Operand/expected table for the zero and maximum-value cases.
  logic [15:0] dir_a [3] = '{16'hFFFF, 16'h1234, 16'h0000};
  logic [15:0] dir_b [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};

  initial begin
    int edges;
    int gap;
    logic [15:0] a, b;
    bit seen_valid;

    n_checks = 0;
    n_fails  = 0;
    A        = '0;
    B        = '0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    rst_n    = 1'b0;

    // Values while reset is held.
    #3;
    checkOutput("reset_inready",  32'(InReady),     32'd1);
    checkOutput("reset_outvalid", 32'(OutValid),    32'd0);
    checkOutput("reset_lo",       32'(ProductLow),  32'd0);
    checkOutput("reset_hi",       32'(ProductHigh), 32'd0);
    checkOutput("reset_ovf",      32'(Overflow),    32'd0);
    #19 rst_n = 1'b1;
    step();

    // 3 x 5. OutValid appears l edges after the accept edge, which is l+1
    // cycles when the accept cycle itself is counted.
    applyStimulus(16'd3, 16'd5);
    waitResult(1'b0, edges);
    checkOutput("basic_latency", 32'(edges), 32'(L));
    checkResult("basic");
    handshake("basic");

    // Maximum product and the two zero-operand cases, each with full latency.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(dir_a[i], dir_b[i]);
      waitResult(1'b0, edges);
      checkOutput($sformatf("dir%0d_latency", i), 32'(edges), 32'(L));
      checkResult($sformatf("dir%0d", i));
      handshake($sformatf("dir%0d", i));
    end

    // Back-pressure: the result holds while OutReady is low.
    // Operand pulses sent during RUN/DONE must not be captured.
    applyStimulus(16'h0100, 16'h0100);
    waitResult(1'b1, edges);
    for (int i = 0; i < 5; i++) begin
      A       = 16'd7;
      B       = 16'd7;
      InValid = (i < 4);
      step();
      checkOutput($sformatf("hold%0d_valid", i), 32'(OutValid),    32'd1);
      checkOutput($sformatf("hold%0d_hi", i),    32'(ProductHigh), 32'h0001);
      checkOutput($sformatf("hold%0d_lo", i),    32'(ProductLow),  32'h0000);
    end
    InValid = 1'b0;
    checkResult("hold");
    handshake("hold");
    applyStimulus(16'd7, 16'd7);
    waitResult(1'b0, edges);
    checkResult("after_hold");
    handshake("after_hold");

    // Reset in the middle of an operation discards the in-flight result.
    applyStimulus(16'hABCD, 16'h1234);
    void'(exp_q.pop_back());
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_inready",  32'(InReady),     32'd1);
    checkOutput("midrst_outvalid", 32'(OutValid),    32'd0);
    checkOutput("midrst_lo",       32'(ProductLow),  32'd0);
    checkOutput("midrst_hi",       32'(ProductHigh), 32'd0);
    checkOutput("midrst_ovf",      32'(Overflow),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * L; i++) begin
      step();
      if (OutValid === 1'b1) seen_valid = 1'b1;
    end
    checkOutput("midrst_no_result", 32'(seen_valid), 32'd0);
    applyStimulus(16'd2, 16'h8000);
    waitResult(1'b0, edges);
    checkResult("post_rst");
    handshake("post_rst");

    // Random operands with random idle gaps and random consumer stalls.
    for (int n = 0; n < 500; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      a = pickOperand();
      b = pickOperand();
      applyStimulus(a, b);
      waitResult(1'b1, edges);
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      checkResult($sformatf("rnd%0d", n));
      handshake($sformatf("rnd%0d", n));
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
